fog_lut_sequencer: RTL and testbench

// - Sequences fog LUT reloads into the fog unit without corrupting pixels in flight.
// - Sits between the command parser's LUT payload stream and the fog unit's LUT stream input.
// - On a load request it:
//   - stalls the pixel pipeline,
//   - waits for the fog pipeline to drain,
//   - forwards exactly LUT_WORDS words, terminated by tlast,
//   - releases the pipeline.

---
 rtl/fog_lut_sequencer_pkg.sv | 17 +
 rtl/fog_lut_sequencer.sv | 146 ++++++++++++++
 tb/tb_fog_lut_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fog_lut_sequencer_pkg.sv
// Shared definitions for the fog LUT reload sequencer: state encoding and default LUT geometry,
// so the command parser, driver and sequencer agree on the LUT size.
package fog_lut_sequencer_pkg;

    localparam int FOG_LUT_WORDS_DEFAULT    = 66;
    localparam int FOG_LUT_DATA_WIDTH       = 32;
    localparam int FOG_DRAIN_CYCLES_DEFAULT = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } fog_seq_state_e;

endpackage

// File: rtl/fog_lut_sequencer.sv
// Stalls the pixel pipeline, waits for the fog pipeline to drain, then forwards exactly
// LUT_WORDS payload words to the fog unit's LUT port, terminated by tlast.
module fog_lut_sequencer
    import fog_lut_sequencer_pkg::*;
#(
    parameter int LUT_WORDS    = FOG_LUT_WORDS_DEFAULT,
    parameter int DATA_WIDTH   = FOG_LUT_DATA_WIDTH,
    parameter int DRAIN_CYCLES = FOG_DRAIN_CYCLES_DEFAULT
) (
    input  logic                  aclk,
    input  logic                  resetn,

    input  logic                  s_cmd_axis_tvalid,
    output logic                  s_cmd_axis_tready,
    input  logic                  s_cmd_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s_cmd_axis_tdata,

    output logic                  m_fog_lut_axis_tvalid,
    input  logic                  m_fog_lut_axis_tready,
    output logic                  m_fog_lut_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_fog_lut_axis_tdata,

    input  logic                  pipe_busy,
    output logic                  pipe_hold,
    output logic                  load_done,
    output logic                  load_error,

    output logic [2:0]            dbg_state_o
);

    localparam int WORD_W  = $clog2(LUT_WORDS);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [WORD_W-1:0]  LAST_WORD  = WORD_W'(LUT_WORDS - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(DRAIN_CYCLES - 1);

    // Handshake: a transfer happens on a cycle where valid and ready are both high; valid never
    // depends on ready. In STREAM the two channels are wired straight through, so the payload
    // source sees the fog unit's ready unchanged and a stalled fog unit stalls the source.

    fog_seq_state_e        state_q, state_d;
    logic [WORD_W-1:0]     word_cnt_q, word_cnt_d;
    logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic                  load_error_q, load_error_d;
    logic                  load_done_q;
    logic                  beat;
    logic                  at_last_word;

    assign beat         = s_cmd_axis_tvalid & m_fog_lut_axis_tready;
    assign at_last_word = (word_cnt_q == LAST_WORD);

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= '0;
            drain_cnt_q  <= '0;
            load_error_q <= 1'b0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            load_error_q <= load_error_d;
            load_done_q  <= (state_d == ST_DONE);
        end
    end

    always_comb begin
        state_d               = state_q;
        word_cnt_d            = word_cnt_q;
        drain_cnt_d           = drain_cnt_q;
        load_error_d          = load_error_q;
        s_cmd_axis_tready     = 1'b0;
        m_fog_lut_axis_tvalid = 1'b0;
        m_fog_lut_axis_tlast  = 1'b0;
        m_fog_lut_axis_tdata  = '0;
        pipe_hold             = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (s_cmd_axis_tvalid) begin
                    state_d      = ST_DRAIN;
                    load_error_d = 1'b0;
                    drain_cnt_d  = '0;
                end
            end

            ST_DRAIN: begin
                pipe_hold = 1'b1;
                // Any busy cycle restarts the count: the idle cycles must be consecutive.
                if (pipe_busy) begin
                    drain_cnt_d = '0;
                end else if (drain_cnt_q == LAST_DRAIN) begin
                    state_d    = ST_STREAM;
                    word_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end

            ST_STREAM: begin
                pipe_hold             = 1'b1;
                m_fog_lut_axis_tvalid = s_cmd_axis_tvalid;
                s_cmd_axis_tready     = m_fog_lut_axis_tready;
                m_fog_lut_axis_tdata  = s_cmd_axis_tdata;
                m_fog_lut_axis_tlast  = at_last_word | s_cmd_axis_tlast;
                if (beat) begin
                    if (at_last_word) begin
                        // Fog unit always receives exactly LUT_WORDS; surplus goes to FLUSH.
                        state_d = s_cmd_axis_tlast ? ST_DONE : ST_FLUSH;
                        if (!s_cmd_axis_tlast) begin
                            load_error_d = 1'b1;
                        end
                    end else if (s_cmd_axis_tlast) begin
                        state_d      = ST_DONE;
                        load_error_d = 1'b1;
                    end else begin
                        word_cnt_d = word_cnt_q + WORD_W'(1);
                    end
                end
            end

            ST_FLUSH: begin
                pipe_hold         = 1'b1;
                s_cmd_axis_tready = 1'b1;
                if (s_cmd_axis_tvalid && s_cmd_axis_tlast) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                pipe_hold = 1'b1;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign load_done   = load_done_q;
    assign load_error  = load_error_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fog_lut_sequencer.sv
// Self-checking bench for fog_lut_sequencer: directed vector table, reset-in-stream sequence,
// and randomized loads checked against a length-arithmetic reference model and a scoreboard.
module tb_fog_lut_sequencer;
  import fog_lut_sequencer_pkg::*;

  localparam int LUT_WORDS = 66;
  localparam int DW        = 32;
  localparam int DRAIN     = 6;
  localparam int BUDGET    = 3000;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic resetn;

  logic          s_tvalid, s_tready, s_tlast;
  logic [DW-1:0] s_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] m_tdata;
  logic          pipe_busy, pipe_hold, load_done, load_error;
  logic [2:0]    dbg_state;

  fog_lut_sequencer #(
    .LUT_WORDS(LUT_WORDS), .DATA_WIDTH(DW), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .aclk                  (aclk),
    .resetn                (resetn),
    .s_cmd_axis_tvalid     (s_tvalid),
    .s_cmd_axis_tready     (s_tready),
    .s_cmd_axis_tlast      (s_tlast),
    .s_cmd_axis_tdata      (s_tdata),
    .m_fog_lut_axis_tvalid (m_tvalid),
    .m_fog_lut_axis_tready (m_tready),
    .m_fog_lut_axis_tlast  (m_tlast),
    .m_fog_lut_axis_tdata  (m_tdata),
    .pipe_busy             (pipe_busy),
    .pipe_hold             (pipe_hold),
    .load_done             (load_done),
    .load_error            (load_error),
    .dbg_state_o           (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_pass   = 0;
  bit            prev_err = 1'b0;
  logic [DW-1:0] exp_q[$];
  bit            exp_last_q[$];
  bit            busy_pat[64];

  typedef struct {
    int    n;
    int    ready_mode;  // 0 always ready, 1 toggling, 2 random
    int    busy_sel;    // 0 idle, 1 restart pattern, 2 random
    bit    gaps;
    int    exp_beats;
    int    exp_disc;
    bit    exp_err;
    int    exp_start;   // cycle (relative to request) of first STREAM cycle
    string name;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic bit busy_at(input int k);
    return (k >= 0 && k < 64) ? busy_pat[k] : 1'b0;
  endfunction

  // Reference: streaming begins the cycle after the first run of DRAIN consecutive idle
  // pipe cycles, counted from the first cycle after the request.
  function automatic int model_start();
    for (int c = DRAIN; c < 200; c++) begin
      bit clear = 1'b1;
      for (int k = c - DRAIN + 1; k <= c; k++)
        if (busy_at(k)) clear = 1'b0;
      if (clear) return c + 1;
    end
    return -1;
  endfunction

  task automatic set_busy(input int sel);
    for (int k = 0; k < 64; k++) busy_pat[k] = 1'b0;
    if (sel == 1) begin
      for (int k = 1; k <= 10; k++) busy_pat[k] = 1'b1;
      busy_pat[14] = 1'b1;
    end else if (sel == 2) begin
      for (int k = 1; k <= 20; k++) busy_pat[k] = ($urandom_range(0, 2) == 0);
    end
  endtask

  // ---------------- driver + monitor for one load ----------------
  task automatic run_load(input int n, input int ready_mode, input bit gaps,
                          input int exp_beats, input int exp_disc, input bit exp_err,
                          input int exp_start, input int abort_at, input string tag);
    logic [DW-1:0] words[$];
    logic [DW-1:0] e;
    bit            el;
    int idx = 0, cyc = 0, beats = 0, disc = 0, start_seen = -1;
    int drain_bad = 0, mirror_bad = 0, sb_beats;
    bit done = 1'b0, aborted = 1'b0, timed_out = 1'b0;

    for (int i = 0; i < n; i++) words.push_back($urandom());
    sb_beats = (n < LUT_WORDS) ? n : LUT_WORDS;
    exp_q.delete();
    exp_last_q.delete();
    for (int i = 0; i < sb_beats; i++) begin
      exp_q.push_back(words[i]);
      exp_last_q.push_back(i == sb_beats - 1);
    end

    while (!done && !aborted && !timed_out) begin
      @(posedge aclk); #1;
      s_tvalid  = (idx < n) && !(gaps && cyc > 0 && $urandom_range(0, 3) == 0);
      s_tdata   = (idx < n) ? words[idx] : '0;
      s_tlast   = (idx == n - 1);
      case (ready_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = (cyc % 2 == 0);
        default: m_tready = ($urandom_range(0, 2) != 0);
      endcase
      pipe_busy = busy_at(cyc);
      @(negedge aclk);
      if (cyc == 0) begin
        check(pipe_hold === 1'b0 && load_done === 1'b0, {tag, "_hold_low_at_req"},
              {pipe_hold, load_done}, 0);
        check(load_error === prev_err, {tag, "_error_sticky"}, load_error, prev_err);
      end
      if (cyc == 1) begin
        check(pipe_hold === 1'b1, {tag, "_hold_rise"}, pipe_hold, 1);
        check(load_error === 1'b0, {tag, "_error_cleared"}, load_error, 0);
      end
      if (start_seen < 0 && dbg_state == ST_STREAM) start_seen = cyc;
      if (cyc >= 1 && start_seen < 0 &&
          (s_tready !== 1'b0 || pipe_hold !== 1'b1 || m_tvalid !== 1'b0)) drain_bad++;
      if (m_tvalid === 1'b1 && s_tready !== m_tready) mirror_bad++;
      if (s_tvalid && s_tready === 1'b1) begin
        if (m_tvalid !== 1'b1) disc++;
        idx++;
      end
      if (m_tvalid === 1'b1 && m_tready) begin
        beats++;
        if (exp_q.size() == 0) begin
          check(1'b0, {tag, "_extra_beat"}, beats, sb_beats);
        end else begin
          e  = exp_q.pop_front();
          el = exp_last_q.pop_front();
          check(m_tdata === e && m_tlast === el, $sformatf("%s_beat%0d", tag, beats - 1),
                {m_tlast, m_tdata}, {el, e});
        end
      end
      if (abort_at > 0 && beats == abort_at) aborted = 1'b1;
      if (load_done === 1'b1) done = 1'b1;
      cyc++;
      if (cyc > BUDGET) begin
        check(1'b0, {tag, "_timeout"}, cyc, BUDGET);
        timed_out = 1'b1;
      end
    end

    if (!aborted) begin
      check(start_seen == exp_start, {tag, "_stream_start"}, start_seen, exp_start);
      check(drain_bad == 0, {tag, "_drain_outputs"}, drain_bad, 0);
      check(mirror_bad == 0, {tag, "_ready_mirror"}, mirror_bad, 0);
      check(beats == exp_beats, {tag, "_beat_count"}, beats, exp_beats);
      check(disc == exp_disc, {tag, "_discarded"}, disc, exp_disc);
      check(idx == n, {tag, "_consumed"}, idx, n);
      check(exp_q.size() == 0, {tag, "_missing_beats"}, exp_q.size(), 0);
      check(load_error === exp_err, {tag, "_load_error"}, load_error, exp_err);
      prev_err = exp_err;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, rmode, start, ebeats, edisc;
    bit gaps;

    resetn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    m_tready = 1'b0; pipe_busy = 1'b0;
    set_busy(0);

    vecs[0] = '{66, 0, 0, 1'b0, 66, 0, 1'b0, 7,  "nominal"};
    vecs[1] = '{66, 0, 1, 1'b0, 66, 0, 1'b0, 21, "drain_restart"};
    vecs[2] = '{66, 1, 0, 1'b0, 66, 0, 1'b0, 7,  "backpressure"};
    vecs[3] = '{41, 0, 0, 1'b0, 41, 0, 1'b1, 7,  "short41"};
    vecs[4] = '{66, 0, 0, 1'b0, 66, 0, 1'b0, 7,  "after_short"};
    vecs[5] = '{70, 0, 0, 1'b0, 66, 4, 1'b1, 7,  "long70"};
    vecs[6] = '{65, 1, 0, 1'b0, 65, 0, 1'b1, 7,  "short65"};
    vecs[7] = '{67, 0, 0, 1'b0, 66, 1, 1'b1, 7,  "long67"};
    vecs[8] = '{1,  0, 0, 1'b0, 1,  0, 1'b1, 7,  "single"};
    vecs[9] = '{66, 2, 0, 1'b1, 66, 0, 1'b0, 7,  "random_flow"};

    repeat (3) @(posedge aclk);
    #1;
    check(pipe_hold === 0 && load_done === 0 && load_error === 0, "reset_status",
          {pipe_hold, load_done, load_error}, 0);
    check(s_tready === 0 && m_tvalid === 0 && m_tlast === 0 && m_tdata === '0, "reset_stream",
          {s_tready, m_tvalid, m_tlast}, 0);
    check(dbg_state == ST_IDLE, "reset_state", dbg_state, 0);
    @(negedge aclk);
    resetn = 1'b1;

    for (int v = 0; v < 10; v++) begin
      set_busy(vecs[v].busy_sel);
      run_load(vecs[v].n, vecs[v].ready_mode, vecs[v].gaps, vecs[v].exp_beats,
               vecs[v].exp_disc, vecs[v].exp_err, vecs[v].exp_start, 0, vecs[v].name);
    end

    // Reset arriving mid-STREAM, after word 20 has been accepted.
    set_busy(0);
    run_load(66, 0, 1'b0, 66, 0, 1'b0, 7, 21, "pre_reset");
    @(posedge aclk); #2;
    resetn = 1'b0;
    #1;
    check(s_tready === 0 && m_tvalid === 0 && m_tlast === 0 && m_tdata === '0,
          "midreset_stream", {s_tready, m_tvalid, m_tlast}, 0);
    check(pipe_hold === 0 && load_done === 0 && load_error === 0, "midreset_status",
          {pipe_hold, load_done, load_error}, 0);
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0; pipe_busy = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    resetn = 1'b1;
    prev_err = 1'b0;
    run_load(66, 0, 1'b0, 66, 0, 1'b0, 7, 0, "post_reset");

    // Randomized loads against the length-arithmetic model.
    for (int r = 0; r < 16; r++) begin
      n      = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 72) : $urandom_range(63, 69);
      rmode  = $urandom_range(0, 2);
      gaps   = $urandom_range(0, 1);
      set_busy(2);
      start  = model_start();
      ebeats = (n < LUT_WORDS) ? n : LUT_WORDS;
      edisc  = (n > LUT_WORDS) ? n - LUT_WORDS : 0;
      run_load(n, rmode, gaps, ebeats, edisc, (n != LUT_WORDS), start, 0,
               $sformatf("rand%0d_n%0d", r, n));
    end

    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    @(negedge aclk);
    check(pipe_hold === 0 && load_done === 0, "final_idle", {pipe_hold, load_done}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
